// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter. The grant is registered and one-hot. A winner keeps
// ownership for up to its weight in consecutive cycles, then priority rotates past it.
// While stall is high, all state is frozen.
module wrr_arbiter #(
    parameter int unsigned CLIENTS  = 32,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned ID_W     = $clog2(CLIENTS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [CLIENTS-1:0]          request,
    input  logic [CLIENTS*WEIGHT_W-1:0] weight,
    input  logic                        mode,
    input  logic                        stall,
    output logic [CLIENTS-1:0]          grant,
    output logic                        grant_valid,
    output logic [ID_W-1:0]             grant_id,
    output logic [WEIGHT_W-1:0]         credit
);

    logic [CLIENTS-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;

    logic [WEIGHT_W-1:0] weight_arr [CLIENTS];
    logic                found;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     cand;
    int unsigned         idx;
    logic [WEIGHT_W-1:0] win_weight;
    logic                continue_burst;

    for (genvar i = 0; i < CLIENTS; i++) begin : g_weight
        assign weight_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end

    // Priority scan starting at ptr, wrapping explicitly at CLIENTS (need not be a power of 2)
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        idx    = 0;
        for (int unsigned k = 0; k < CLIENTS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= CLIENTS) begin
                idx = idx - CLIENTS;
            end
            cand = ID_W'(idx);
            if (!found && request[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign win_weight = weight_arr[winner];

    // The burst continues only while the owner still asks, weighted mode holds and credit remains
    assign continue_burst = grant_valid && request[id_q] && mode && (credit_q > WEIGHT_W'(1));

    // Next-state: either continue the burst or re-arbitrate
    always_comb begin
        grant_d  = grant_q;
        id_d     = id_q;
        credit_d = credit_q;
        ptr_d    = ptr_q;
        if (continue_burst) begin
            credit_d = credit_q - WEIGHT_W'(1);
        end else if (found) begin
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            id_d            = winner;
            ptr_d           = (winner == ID_W'(CLIENTS - 1)) ? '0 : winner + ID_W'(1);
            // A zero weight still earns a single cycle
            credit_d        = (mode && (win_weight != '0)) ? win_weight : WEIGHT_W'(1);
        end else begin
            grant_d  = '0;
            id_d     = '0;
            credit_d = '0;
        end
    end

    // State register: reset wins over stall, and stall freezes everything
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            grant_q  <= '0;
            id_q     <= '0;
            credit_q <= '0;
            ptr_q    <= '0;
        end else if (!stall) begin
            grant_q  <= grant_d;
            id_q     <= id_d;
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = id_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter. It drives a 32-client instance and a 5-client instance, which
// checks wrap-around for a client count that is not a power of 2. A behavioural model
// checks both instances on every cycle. Directed phases add literal expectations.
module tb_wrr_arbiter;

    localparam int unsigned NA = 32;
    localparam int unsigned NB = 5;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         mode;
    logic         stall;
    logic [31:0]  req_a;
    logic [127:0] wt_a;
    logic [4:0]   req_b;
    logic [19:0]  wt_b;

    logic [31:0]  grant_a;
    logic         gv_a;
    logic [4:0]   id_a;
    logic [3:0]   cr_a;
    logic [4:0]   grant_b;
    logic         gv_b;
    logic [2:0]   id_b;
    logic [3:0]   cr_b;

    always #5 clock = ~clock;

    wrr_arbiter #(.CLIENTS(NA), .WEIGHT_W(4)) u_dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .request     (req_a),
        .weight      (wt_a),
        .mode        (mode),
        .stall       (stall),
        .grant       (grant_a),
        .grant_valid (gv_a),
        .grant_id    (id_a),
        .credit      (cr_a)
    );

    wrr_arbiter #(.CLIENTS(NB), .WEIGHT_W(4)) u_dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .request     (req_b),
        .weight      (wt_b),
        .mode        (mode),
        .stall       (stall),
        .grant       (grant_b),
        .grant_valid (gv_b),
        .grant_id    (id_b),
        .credit      (cr_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state per instance: owner, remaining burst cycles and priority start
    bit          m_valid  [2];
    int unsigned m_owner  [2];
    int unsigned m_credit [2];
    int unsigned m_ptr    [2];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step(int i, int unsigned n, logic [31:0] req,
                                       logic [127:0] wts);
        bit          hit;
        int unsigned w;
        int unsigned c;
        int unsigned wv;
        hit = 1'b0;
        w   = 0;
        if (!reset_n) begin
            m_valid[i]  = 1'b0;
            m_owner[i]  = 0;
            m_credit[i] = 0;
            m_ptr[i]    = 0;
        end else if (!stall) begin
            if (m_valid[i] && req[m_owner[i]] && mode && m_credit[i] > 1) begin
                m_credit[i] = m_credit[i] - 1;
            end else begin
                for (int unsigned k = 0; k < n; k++) begin
                    c = (m_ptr[i] + k) % n;
                    if (!hit && req[c]) begin
                        hit = 1'b1;
                        w   = c;
                    end
                end
                if (hit) begin
                    wv          = int'((wts >> (w * 4)) & 128'd15);
                    m_valid[i]  = 1'b1;
                    m_owner[i]  = w;
                    m_ptr[i]    = (w + 1) % n;
                    m_credit[i] = mode ? ((wv == 0) ? 1 : wv) : 1;
                end else begin
                    m_valid[i]  = 1'b0;
                    m_owner[i]  = 0;
                    m_credit[i] = 0;
                end
            end
        end
    endfunction

    // The model advances on each rising edge. Inputs only change 1 time unit after an edge.
    always @(posedge clock) begin
        model_step(0, NA, req_a, wt_a);
        model_step(1, NB, {27'b0, req_b}, {108'b0, wt_b});
    end

    // Compare both instances against the model at every falling edge
    always @(negedge clock) begin
        if (chk_en) begin
            check("a.grant", grant_a, m_valid[0] ? (64'd1 << m_owner[0]) : 64'd0);
            check("a.grant_valid", gv_a, m_valid[0]);
            check("a.grant_id", id_a, m_owner[0]);
            check("a.credit", cr_a, m_credit[0]);
            check("b.grant", grant_b, m_valid[1] ? (64'd1 << m_owner[1]) : 64'd0);
            check("b.grant_valid", gv_b, m_valid[1]);
            check("b.grant_id", id_b, m_owner[1]);
            check("b.credit", cr_b, m_credit[1]);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int exp_ids [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
    int exp_crs [10] = '{3, 2, 1, 1, 2, 1, 1, 3, 2, 1};

    initial begin
        reset_n = 1'b0;
        mode    = 1'b0;
        stall   = 1'b0;
        req_a   = '0;
        req_b   = '0;
        wt_a    = '0;
        wt_b    = '0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst.grant", grant_a, 0);
        check("rst.credit", cr_a, 0);
        reset_n = 1'b1;

        // Idle after reset
        repeat (5) begin
            tick();
            check("idle.grant_valid", gv_a, 0);
            check("idle.credit", cr_a, 0);
        end

        // Plain round-robin over all 32 clients
        req_a = '1;
        for (int k = 0; k < 33; k++) begin
            tick();
            check("rr.grant_id", id_a, k % 32);
            check("rr.credit", cr_a, 1);
        end
        req_a = '0;

        // Weighted: weights {3,0,2,1} on clients 0..3 of the 5-client instance
        mode  = 1'b1;
        wt_b  = {4'd0, 4'd1, 4'd2, 4'd0, 4'd3};
        req_b = 5'b01111;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("wrr.grant_id", id_b, exp_ids[k]);
            check("wrr.credit", cr_b, exp_crs[k]);
        end
        req_b = '0;

        // Early release: client 5 drops at credit 5, client 9 takes over
        wt_a          = '0;
        wt_a[20 +: 4] = 4'd8;
        wt_a[36 +: 4] = 4'd3;
        req_a         = 32'd1 << 5;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rel.grant_id", id_a, 5);
            check("rel.credit", cr_a, 8 - k);
        end
        req_a = 32'd1 << 9;
        tick();
        check("rel.new_id", id_a, 9);
        check("rel.new_credit", cr_a, 3);
        req_a = '0;
        tick();
        check("rel.drop_valid", gv_a, 0);

        // Stall freezes a burst in place
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wt_a    = {32{4'd4}};
        req_a   = '1;
        tick();
        check("stl.start_credit", cr_a, 4);
        tick();
        check("stl.pre_credit", cr_a, 3);
        stall = 1'b1;
        repeat (4) begin
            tick();
            check("stl.grant", grant_a, 1);
            check("stl.credit", cr_a, 3);
        end
        stall = 1'b0;
        tick();
        check("stl.resume_id", id_a, 0);
        check("stl.resume_credit", cr_a, 2);

        // Reset overrides stall mid-burst
        stall   = 1'b1;
        reset_n = 1'b0;
        tick();
        check("rs.grant", grant_a, 0);
        check("rs.credit", cr_a, 0);
        reset_n = 1'b1;
        stall   = 1'b0;
        req_a   = (32'd1 << 7) | (32'd1 << 3) | (32'd1 << 20);
        tick();
        check("rs.first_id", id_a, 3);
        check("rs.first_credit", cr_a, 4);

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_a = req_a ^ ($urandom & $urandom & $urandom);
            req_b = req_b ^ 5'($urandom & $urandom);
            if ($urandom_range(0, 63) == 0) req_a = '1;
            if ($urandom_range(0, 63) == 0) req_b = '1;
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < 4; j++) wt_a[j*32 +: 32] = $urandom;
                wt_b = 20'($urandom);
            end
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            stall   = ($urandom_range(0, 7) == 0);
            reset_n = ($urandom_range(0, 149) != 0);
            tick();
        end
        reset_n = 1'b1;
        stall   = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Parametrised successor to rr_arbiter: round-robin arbiter over CLIENTS requesters with per-client burst weights, a plain/weighted mode select and stall freeze.
- Sits between request sources and a shared resource.
- Grant is registered and one-hot. A granted client holds ownership for up to its weight in consecutive cycles before priority rotates.

Parameters:
- CLIENTS, 32, number of requesters; any value >= 2, power of 2 not required.
- WEIGHT_W, 4, width of each per-client weight field.
- ID_W, $clog2(CLIENTS), width of grant_id.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- request  input  CLIENTS  per-client request; bit i belongs to client i.
- weight  input  CLIENTS*WEIGHT_W  client i weight in bits [i*WEIGHT_W +: WEIGHT_W]; sampled only when a burst starts.
- mode  input  1  0 = plain round-robin (burst length 1); 1 = weighted.
- stall  input  1  freezes all state and outputs while high.
- grant  output  CLIENTS  registered one-hot grant, or all-zero.
- grant_valid  output  1  equals |grant.
- grant_id  output  ID_W  index of the granted client; 0 when grant_valid=0.
- credit  output  WEIGHT_W  cycles remaining in the current burst, including the current cycle.

Behaviour:
- Reset (reset_n=0 at a rising edge): grant=0, grant_valid=0, grant_id=0, credit=0, priority pointer=0. Reset overrides stall.
- Latency: outputs are registered. Request sampled at edge N produces grant visible after edge N; no combinational path from request to grant.
- State: ptr (highest-priority index), owner (grant_id), credit.
- When stall=1 at an edge, no state or output changes.
- When stall=0, each edge evaluates the following in order:
  1. Continue: grant_valid=1 and request[owner]=1 and mode=1 and credit>1. Keep grant; credit <= credit-1; ptr unchanged.
  2. Arbitrate, otherwise. Scan request starting at ptr, incrementing and wrapping modulo CLIENTS; the first set bit wins.
     - Winner w: grant <= one-hot(w), grant_id <= w, ptr <= (w+1) mod CLIENTS.
     - credit <= (mode=1) ? max(weight[w],1) : 1. A weight of 0 is treated as 1.
     - No request set: grant <= 0, grant_valid <= 0, grant_id <= 0, credit <= 0, ptr unchanged.
- Early release: if the owner drops its request mid-burst, it forfeits the remaining credit and re-arbitration happens at that edge.
- Re-grant: the owner may win again on re-arbitration only if it is the sole requester (ptr has already moved past it). It then gets a fresh burst with the weight re-sampled.
- Fairness: with all clients requesting continuously and no stall, client i is granted weight[i] consecutive cycles, then client i+1 takes over.
  - No client waits more than the sum of the other clients' effective weights.
- Mode change:
  - Mode is evaluated each edge.
  - Dropping mode to 0 mid-burst ends the burst at the next unstalled edge.
  - Raising mode to 1 only affects bursts that start afterwards.
- Wrap: for non-power-of-2 CLIENTS, ptr wraps from CLIENTS-1 to 0. Out-of-range indices never occur.
- Reset mid-burst: all outputs return to reset values after the edge; the pending burst is discarded.
- Invariants: $onehot0(grant); grant_valid == |grant; grant_valid -> grant[grant_id]; credit==0 iff grant_valid==0.
  - A grant only goes to a client that requested at the previous unstalled edge.

Test Plan:
- Reset release, request=0 for 5 cycles -> grant=0, grant_valid=0, credit=0 every cycle.
- mode=0, request=all ones, no stall -> grant cycles 0,1,2,...,31,0, one cycle each, starting one cycle after request rises.
- mode=1, CLIENTS=4, weights {3,0,2,1}, request=4'b1111 -> grant sequence 0,0,0,1,2,2,3,0,0,0; credit counts 3,2,1,1,2,1,1,3...
- mode=1, weight[5]=8, client 5 sole requester drops request when credit=5 -> grant=0 after next edge; client 9 requesting at the same time gets the grant instead, credit=max(weight[9],1).
- Mid-burst stall held for 4 cycles -> grant, grant_id and credit identical throughout; burst resumes with the same credit after stall falls.
- Assert reset_n=0 while stall=1 during a burst -> grant=0, credit=0 after the edge; the first post-reset grant goes to the lowest-index requester.
